// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the RV32 pipeline control slice.
//   pipe_state_e : sequencer states (RUN, MEM_WAIT, REDIRECT)
//   REG_IDX_W    : architectural register index width
//   NOP_INSTR    : instruction loaded into IF/ID on a flush (addi x0,x0,0)
//   FLUSH_PC     : PC value tagged onto a flushed IF/ID entry
package pipe_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] FLUSH_PC  = 32'hffffffff;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
// Ports:
//   id_rs1, id_rs2         in  source registers of the instruction in ID
//   id_use_rs1, id_use_rs2 in  ID instruction actually reads that source
//   ex_valid, ex_is_load   in  EX holds a real load
//   ex_rd                  in  EX destination register
//   load_use               out ID needs a value the EX load has not produced yet
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for
  assign load_use = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage RV32 pipeline.
// Priority: data-memory wait > EX redirect > load-use hazard.
// Parameters:
//   REDIR_CYCLES : extra IF/ID flush cycles after a redirect (0..15)
//   MEM_TIMEOUT  : MEM_WAIT cycles before mem_err is raised (1..65535)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/rs2, id_use_rs*   ID source operands
//   ex_valid, ex_is_load,
//   ex_rd, ex_redirect       EX status
//   mem_req, mem_ack         MEM data access handshake
//   pc_hold .. mem_wb_bubble pipeline register controls (combinational)
//   mem_err                  sticky memory-timeout flag
//   perf_stall_cnt/flush_cnt performance counters
// Optional feature: define PIPE_CTRL_PERF_EN to build the performance
// counters; otherwise both counter ports are tied to 0.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REDIR_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 if_id_flush,
  output logic                 id_ex_hold,
  output logic                 id_ex_flush,
  output logic                 ex_mem_hold,
  output logic                 mem_wb_bubble,
  output logic                 mem_err,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
);

  localparam logic [4:0]  REDIR_LOAD     = 5'(REDIR_CYCLES);
  localparam logic [4:0]  REDIR_LOAD_EXT = 5'(REDIR_CYCLES + 1);
  localparam logic [15:0] TIMEOUT_V      = 16'(MEM_TIMEOUT);

  pipe_state_e state;
  logic [4:0]  redir_cnt;
  logic        redir_pend;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        mem_err_q;

  logic load_use;
  logic mem_stall;

  logic pc_hold_c;
  logic if_id_hold_c;
  logic if_id_flush_c;
  logic id_ex_hold_c;
  logic id_ex_flush_c;
  logic ex_mem_hold_c;
  logic mem_wb_bubble_c;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ack;

  // Saturating so a memory that never answers cannot wrap the counter and re-arm the timeout
  assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 16'd1;

  // Controls must act in the cycle the condition appears, so they are decoded
  // from the current state and inputs rather than registered.
  always_comb begin
    pc_hold_c       = 1'b0;
    if_id_hold_c    = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_hold_c    = 1'b0;
    id_ex_flush_c   = 1'b0;
    ex_mem_hold_c   = 1'b0;
    mem_wb_bubble_c = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pc_hold_c       = 1'b1;
            if_id_hold_c    = 1'b1;
            id_ex_hold_c    = 1'b1;
            ex_mem_hold_c   = 1'b1;
            mem_wb_bubble_c = 1'b1;
          end else if (ex_redirect) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (load_use) begin
            pc_hold_c     = 1'b1;
            if_id_hold_c  = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_hold_c       = 1'b1;
          if_id_hold_c    = 1'b1;
          id_ex_hold_c    = 1'b1;
          ex_mem_hold_c   = 1'b1;
          // On the ack cycle MEM/WB captures the load result instead of a bubble
          mem_wb_bubble_c = !mem_ack;
        end
        REDIRECT: begin
          if (mem_stall) begin
            pc_hold_c       = 1'b1;
            if_id_hold_c    = 1'b1;
            id_ex_hold_c    = 1'b1;
            ex_mem_hold_c   = 1'b1;
            mem_wb_bubble_c = 1'b1;
          end else begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = ex_redirect;
          end
        end
        default: ;
      endcase
    end
  end

  // Flush wins over hold on the same pipeline register
  assign pc_hold       = pc_hold_c;
  assign if_id_flush   = if_id_flush_c;
  assign if_id_hold    = if_id_hold_c && !if_id_flush_c;
  assign id_ex_flush   = id_ex_flush_c;
  assign id_ex_hold    = id_ex_hold_c && !id_ex_flush_c;
  assign ex_mem_hold   = ex_mem_hold_c;
  assign mem_wb_bubble = mem_wb_bubble_c;
  assign mem_err       = mem_err_q && !rst;

  // Sequencer state, redirect/wait counters and the sticky timeout flag.
  // A redirect seen while waiting on memory is parked in redir_pend and
  // replayed once the access completes, with one extra flush cycle because
  // the fetch that was in flight during the wait is also stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      redir_cnt  <= '0;
      redir_pend <= 1'b0;
      wait_cnt   <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
            if (ex_redirect) redir_pend <= 1'b1;
          end else if (ex_redirect && (REDIR_CYCLES != 0)) begin
            redir_cnt <= REDIR_LOAD;
            state     <= REDIRECT;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (redir_pend || ex_redirect) begin
              state      <= REDIRECT;
              redir_cnt  <= REDIR_LOAD_EXT;
              redir_pend <= 1'b0;
            end else begin
              state <= RUN;
            end
          end else begin
            if (ex_redirect) redir_pend <= 1'b1;
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_V) mem_err_q <= 1'b1;
          end
        end
        REDIRECT: begin
          if (mem_stall) begin
            state      <= MEM_WAIT;
            wait_cnt   <= '0;
            redir_pend <= 1'b1;
          end else if (ex_redirect) begin
            if (REDIR_CYCLES == 0) begin
              state <= RUN;
            end else begin
              redir_cnt <= REDIR_LOAD;
            end
          end else if (redir_cnt <= 5'd1) begin
            redir_cnt <= '0;
            state     <= RUN;
          end else begin
            redir_cnt <= redir_cnt - 5'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running event counters; they wrap rather than saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold_c)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush_c) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = rst ? 32'd0 : stall_cnt_q;
  assign perf_flush_cnt = rst ? 32'd0 : flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl with
// REDIR_CYCLES=2 and MEM_TIMEOUT=4. Expected control vectors are written
// per cycle; expected perf counts are accumulated from those vectors.
// Control vector bit order:
//   [7] pc_hold [6] if_id_hold [5] if_id_flush [4] id_ex_hold
//   [3] id_ex_flush [2] ex_mem_hold [1] mem_wb_bubble [0] mem_err
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ack;
  logic        pc_hold;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_hold;
  logic        id_ex_flush;
  logic        ex_mem_hold;
  logic        mem_wb_bubble;
  logic        mem_err;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] HOLDB = 8'hD6;
  localparam logic [7:0] HOLDN = 8'hD4;
  localparam logic [7:0] REDIR = 8'h28;
  localparam logic [7:0] FLSH  = 8'h20;
  localparam logic [7:0] LDUSE = 8'hC8;

  int checks_total  = 0;
  int checks_passed = 0;
  int exp_stall     = 0;
  int exp_flush     = 0;

  pipe_ctrl #(
    .REDIR_CYCLES (2),
    .MEM_TIMEOUT  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_redirect    (ex_redirect),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_hold     (id_ex_hold),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_hold    (ex_mem_hold),
    .mem_wb_bubble  (mem_wb_bubble),
    .mem_err        (mem_err),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    else
      checks_passed++;
  endtask

  // Drives one cycle of inputs just after the falling edge
  task automatic applyStimulus(input logic r, input logic redir, input logic req, input logic ack,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic exv, input logic exl, input logic [4:0] rd);
    @(negedge clk);
    rst         = r;
    ex_redirect = redir;
    mem_req     = req;
    mem_ack     = ack;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    ex_valid    = exv;
    ex_is_load  = exl;
    ex_rd       = rd;
  endtask

  // Checks the current cycle well before the next rising edge, then
  // advances the expected perf counts by what this cycle should add
  task automatic checkCycle(input string tag, input logic [7:0] exp_vec);
    logic [7:0]  vec;
    logic [31:0] es;
    logic [31:0] ef;
    #1;
    vec = {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
           id_ex_flush, ex_mem_hold, mem_wb_bubble, mem_err};
    checkOutput($sformatf("%s/ctrl", tag), {24'd0, vec}, {24'd0, exp_vec});
`ifdef PIPE_CTRL_PERF_EN
    es = rst ? 32'd0 : 32'(exp_stall);
    ef = rst ? 32'd0 : 32'(exp_flush);
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    checkOutput($sformatf("%s/perf_stall", tag), perf_stall_cnt, es);
    checkOutput($sformatf("%s/perf_flush", tag), perf_flush_cnt, ef);
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      exp_stall += int'(exp_vec[7]);
      exp_flush += int'(exp_vec[5]);
    end
  endtask

  // Shorthand: no load-use operands
  task automatic cyc(input string tag, input logic r, input logic redir, input logic req,
                     input logic ack, input logic [7:0] exp_vec);
    applyStimulus(r, redir, req, ack, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    checkCycle(tag, exp_vec);
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;

    // reset forces outputs low even with active requests
    cyc("reset0", 1, 1, 1, 0, NONE);
    cyc("reset1", 1, 0, 0, 0, NONE);
    cyc("idle",   0, 0, 0, 0, NONE);

    // load-use on rs2, then hazard gone
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd5, 0, 1, 1, 1, 5'd5); checkCycle("lu_rs2", LDUSE);
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd5, 0, 1, 1, 0, 5'd5); checkCycle("lu_rs2_clear", NONE);
    // x0 destination never stalls
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 1, 1, 1, 5'd0); checkCycle("lu_x0", NONE);
    // rs1 match, then invalid EX, then operand not used
    applyStimulus(0, 0, 0, 0, 5'd7, 5'd0, 1, 0, 1, 1, 5'd7); checkCycle("lu_rs1", LDUSE);
    applyStimulus(0, 0, 0, 0, 5'd7, 5'd0, 1, 0, 0, 1, 5'd7); checkCycle("lu_exinv", NONE);
    applyStimulus(0, 0, 0, 0, 5'd7, 5'd0, 0, 0, 1, 1, 5'd7); checkCycle("lu_unused", NONE);

    // memory wait: 3 cycles no ack, then ack
    cyc("mw0",   0, 0, 1, 0, HOLDB);
    cyc("mw1",   0, 0, 1, 0, HOLDB);
    cyc("mw2",   0, 0, 1, 0, HOLDB);
    cyc("mwack", 0, 0, 1, 1, HOLDN);
    cyc("mwrun", 0, 0, 0, 0, NONE);

    // redirect pulse: flush 3 cycles, id_ex_flush on first only
    cyc("rd0",   0, 1, 0, 0, REDIR);
    cyc("rd1",   0, 0, 0, 0, FLSH);
    cyc("rd2",   0, 0, 0, 0, FLSH);
    cyc("rdrun", 0, 0, 0, 0, NONE);

    // load-use suppressed while in REDIRECT
    cyc("rl0", 0, 1, 0, 0, REDIR);
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd0, 1, 0, 1, 1, 5'd3); checkCycle("rl1_sup", FLSH);
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd0, 1, 0, 1, 1, 5'd3); checkCycle("rl2_sup", FLSH);
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd0, 1, 0, 1, 1, 5'd3); checkCycle("rl3_run", LDUSE);
    cyc("rl4", 0, 0, 0, 0, NONE);

    // simultaneous redirect and memory stall: wait first, then 3 flush cycles
    cyc("sim0",   0, 1, 1, 0, HOLDB);
    cyc("sim1",   0, 0, 1, 0, HOLDB);
    cyc("simack", 0, 0, 1, 1, HOLDN);
    cyc("simf0",  0, 0, 0, 0, FLSH);
    cyc("simf1",  0, 0, 0, 0, FLSH);
    cyc("simf2",  0, 0, 0, 0, FLSH);
    cyc("simrun", 0, 0, 0, 0, NONE);

    // new redirect inside REDIRECT reloads the count
    cyc("rr0",   0, 1, 0, 0, REDIR);
    cyc("rr1",   0, 0, 0, 0, FLSH);
    cyc("rr2",   0, 1, 0, 0, REDIR);
    cyc("rr3",   0, 0, 0, 0, FLSH);
    cyc("rr4",   0, 0, 0, 0, FLSH);
    cyc("rrrun", 0, 0, 0, 0, NONE);

    // memory stall interrupts REDIRECT, redirect replayed after ack
    cyc("rm0",   0, 1, 0, 0, REDIR);
    cyc("rm1",   0, 0, 1, 0, HOLDB);
    cyc("rmack", 0, 0, 1, 1, HOLDN);
    cyc("rmf0",  0, 0, 0, 0, FLSH);
    cyc("rmf1",  0, 0, 0, 0, FLSH);
    cyc("rmf2",  0, 0, 0, 0, FLSH);
    cyc("rmrun", 0, 0, 0, 0, NONE);

    // timeout: entry cycle plus 4 wait cycles, then mem_err
    cyc("to_in", 0, 0, 1, 0, HOLDB);
    cyc("to_w1", 0, 0, 1, 0, HOLDB);
    cyc("to_w2", 0, 0, 1, 0, HOLDB);
    cyc("to_w3", 0, 0, 1, 0, HOLDB);
    cyc("to_w4", 0, 0, 1, 0, HOLDB);
    cyc("to_err", 0, 0, 1, 0, HOLDB | 8'h01);
    cyc("to_ack", 0, 0, 1, 1, HOLDN | 8'h01);
    cyc("to_sticky", 0, 0, 0, 0, 8'h01);
    cyc("to_w_again", 0, 0, 1, 0, HOLDB | 8'h01);

    // reset mid-wait clears mem_err and everything
    cyc("to_rst",   1, 0, 1, 0, NONE);
    cyc("post_rst", 0, 0, 0, 0, NONE);

    // reset mid-redirect leaves no residual flush
    cyc("rx0",    0, 1, 0, 0, REDIR);
    cyc("rx_rst", 1, 0, 0, 0, NONE);
    cyc("rx1",    0, 0, 0, 0, NONE);
    cyc("rx2",    0, 0, 0, 0, NONE);

    // one more stall after reset so the counters restart from zero
    cyc("fin0", 0, 0, 1, 1, NONE);
    cyc("fin1", 0, 0, 1, 0, HOLDB);
    cyc("fin2", 0, 0, 1, 1, HOLDN);
    cyc("fin3", 0, 0, 0, 0, NONE);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Consumes hazard and status information from the ID, EX and MEM stages.
- Drives hold/flush controls for the PC register and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles, in a fixed priority, data-memory wait states, EX-resolved control redirects and load-use hazards.

Parameters:
- REDIR_CYCLES, 1: extra cycles of IF/ID flush after a redirect, to cover instruction-fetch latency (0..15).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before mem_err is raised (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_valid  in  1  EX holds a real instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  EX resolved taken branch/jump, PC being redirected
- mem_req  in  1  MEM stage issuing a data access
- mem_ack  in  1  data memory completes the access this cycle
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its contents
- if_id_flush  out  1  IF/ID loads NOP, pc=32'hffffffff
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_flush  out  1  ID/EX loads bubble
- ex_mem_hold  out  1  EX/MEM keeps its contents
- mem_wb_bubble  out  1  MEM/WB loads bubble
- mem_err  out  1  sticky memory-timeout flag
- perf_stall_cnt  out  32  stall-cycle count (optional feature)
- perf_flush_cnt  out  32  flush-cycle count (optional feature)

Behaviour:
- Reset is rst, synchronous, active-high.
  - While rst is high, all outputs are 0.
  - After reset: state=RUN, counters=0, redir_pend=0, mem_err=0.
  - rst asserted mid-operation aborts any wait or redirect with no residual flush.
- flush has precedence over hold on the same register.
- States:
  - RUN
  - MEM_WAIT
  - REDIRECT
- RUN, evaluated in priority order:
  - mem_req && !mem_ack:
    - go to MEM_WAIT this cycle.
    - Assert pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble.
    - If ex_redirect is also high, set redir_pend.
  - ex_redirect:
    - Assert if_id_flush and id_ex_flush this cycle.
    - If REDIR_CYCLES>0, load redir_cnt=REDIR_CYCLES and go to REDIRECT; otherwise stay in RUN.
  - Load-use hazard, defined as ex_valid && ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)):
    - Assert pc_hold, if_id_hold, id_ex_flush for exactly this cycle.
    - Stay in RUN. The hazard naturally clears the next cycle.
  - Otherwise all controls are 0.
- MEM_WAIT:
  - Outputs as on entry.
  - wait_cnt increments each cycle, saturating.
  - When wait_cnt reaches MEM_TIMEOUT, set mem_err; it stays set until rst. The state does not change.
  - ex_redirect seen in this state sets redir_pend.
  - On mem_ack, hold outputs stay asserted that cycle, except mem_wb_bubble=0 (the result is captured). Clear wait_cnt. Next state:
    - redir_pend: REDIRECT with redir_cnt=REDIR_CYCLES+1, clear redir_pend.
    - otherwise RUN.
- REDIRECT:
  - Assert if_id_flush.
  - Decrement redir_cnt; return to RUN when it reaches 0.
  - A new ex_redirect reloads redir_cnt=REDIR_CYCLES and also asserts id_ex_flush.
  - mem_req && !mem_ack takes precedence: go to MEM_WAIT and set redir_pend.
- Load-use detection is suppressed outside RUN.
- Register x0 never creates a hazard.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN
- Defined:
  - perf_stall_cnt increments on every cycle with pc_hold=1.
  - perf_flush_cnt increments on every cycle with if_id_flush=1.
  - Both are 32-bit, wrap modulo 2^32 and are cleared by rst.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared package pipe_pkg:
  - state enum pipe_state_e {RUN, MEM_WAIT, REDIRECT}
  - REG_IDX_W=5
  - NOP instruction constant 32'h00000013
  - FLUSH_PC constant 32'hffffffff
- Sub-module hazard_detect (combinational load-use compare, one output load_use), instantiated once.
- FSM, counters and output decode live in pipe_ctrl.

Test Plan:
- Load-use:
  - Stimulus: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1.
  - Response: one cycle of pc_hold=if_id_hold=id_ex_flush=1, then all 0.
  - Same with ex_rd=0: no stall.
- Memory wait:
  - Stimulus: mem_req=1, mem_ack low for 3 cycles then high.
  - Response: holds asserted for 4 cycles; mem_wb_bubble=1 for the first 3 only; state back to RUN.
- Redirect:
  - Stimulus: ex_redirect pulse with REDIR_CYCLES=2.
  - Response: if_id_flush high 3 consecutive cycles; id_ex_flush high on the first cycle only.
- Simultaneous events:
  - Stimulus: ex_redirect and mem_req=1/mem_ack=0 together, ack after 2 cycles.
  - Response: MEM_WAIT first, then REDIRECT with if_id_flush for REDIR_CYCLES+1 cycles.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_ack never asserted.
  - Response: mem_err rises after 4 wait cycles; rst clears mem_err and all outputs the next edge.
- Performance counters:
  - Stimulus: PIPE_CTRL_PERF_EN defined, run the above sequence.
  - Response: perf_stall_cnt equals the number of pc_hold cycles; undefined build reads 0.
